// File: rtl/iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : iram_arbiter
// Description : Three-state fetch arbiter that shares one synchronous IRAM
//               among NCORES cores. The default policy is round-robin. Define
//               IARB_FIXED_PRIO_EN to make the lowest-index core always win.
// Revision    : 1.0 - initial release
// ============================================================================
module iram_arbiter #(
    parameter int NCORES = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES*AW-1:0] Address,
    input  logic [DW-1:0]        RAMq,
    output logic [AW-1:0]        RAMAddress,
    output logic [NCORES-1:0]    acq,
    output logic [NCORES*DW-1:0] Dq,
    output logic [NCORES-1:0]    dvalid,
    output logic                 busy
);

    localparam int C_PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t            r_state;
    logic [C_PW-1:0]   r_ptr;
    logic [C_PW-1:0]   r_win;
    logic [NCORES-1:0] r_acq;
    logic [NCORES-1:0] r_dvalid;
    logic [DW-1:0]     r_dq [NCORES];

    logic [NCORES-1:0] w_req;
    logic [AW-1:0]     w_addr [NCORES];
    logic [C_PW-1:0]   w_win;
    logic [NCORES-1:0] w_grant;
    logic [C_PW-1:0]   w_ptr_nxt;

    // Internal vectors are core-indexed; the ports put core 0 in the top slice.
    for (genvar i = 0; i < NCORES; i++) begin : g_pack
        assign w_req[i]                      = req[NCORES-1-i];
        assign w_addr[i]                     = Address[(NCORES-1-i)*AW +: AW];
        assign Dq[(NCORES-1-i)*DW +: DW]     = r_dq[i];
        assign acq[NCORES-1-i]               = r_acq[i];
        assign dvalid[NCORES-1-i]            = r_dvalid[i];
    end

`ifdef IARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (w_req[i]) w_win = C_PW'(i);
        end
    end
`else
    logic [C_PW-1:0] w_win_lo;
    logic [C_PW-1:0] w_win_hi;
    logic            w_hi_found;

    // Lowest requester at or above ptr, else lowest overall (the wrap case).
    always_comb begin
        w_win_lo   = '0;
        w_win_hi   = '0;
        w_hi_found = 1'b0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win_lo = C_PW'(i);
                if (C_PW'(i) >= r_ptr) begin
                    w_win_hi   = C_PW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_win = w_hi_found ? w_win_hi : w_win_lo;
    end
`endif

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_grant[i] = (C_PW'(i) == w_win);
        end
    end

    assign w_ptr_nxt = (r_win == C_PW'(NCORES - 1)) ? '0 : r_win + C_PW'(1);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_win      <= '0;
            r_acq      <= '0;
            r_dvalid   <= '0;
            RAMAddress <= '0;
            for (int i = 0; i < NCORES; i++) begin
                r_dq[i] <= '0;
            end
        end else begin
            r_dvalid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        RAMAddress <= w_addr[w_win];
                        r_acq      <= w_grant;
                        r_win      <= w_win;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_state <= ST_DATA;
                end
                ST_DATA: begin
                    // r_acq is already one-hot on the winner, so it doubles as the pulse.
                    r_dq[r_win] <= RAMq;
                    r_dvalid    <= r_acq;
                    r_acq       <= '0;
`ifdef IARB_FIXED_PRIO_EN
                    r_ptr       <= '0;
`else
                    r_ptr       <= w_ptr_nxt;
`endif
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iram_arbiter
// Description : Vector table plus scoreboard bench for iram_arbiter (2 cores).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [7:0]  a0, a1;
    logic [15:0] Address;
    logic [7:0]  RAMq;
    logic [7:0]  RAMAddress;
    logic [1:0]  acq;
    logic [15:0] Dq;
    logic [1:0]  dvalid;
    logic        busy;

    logic [7:0]  mem [256];

    assign Address = {a0, a1};

    iram_arbiter #(.NCORES(2), .AW(8), .DW(8)) dut (
        .CLK        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .Address    (Address),
        .RAMq       (RAMq),
        .RAMAddress (RAMAddress),
        .acq        (acq),
        .Dq         (Dq),
        .dvalid     (dvalid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous single-port IRAM: registers the address, word valid next cycle.
    always @(posedge clk) RAMq <= mem[RAMAddress];

    typedef struct packed {
        logic [1:0] dv;
        logic       core;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [1:0] req;
        logic [7:0] a0;
        logic [7:0] a1;
        bit         drop;
        bit         core;
    } vec_t;

`ifdef IARB_FIXED_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples just after the falling edge; rst_seen is the reset level
    // the DUT saw at the preceding rising edge.
    logic       rst_seen = 1'b0;
    logic [7:0] m0 = 8'h00;
    logic [7:0] m1 = 8'h00;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_seen) begin
                sb_q.delete();
                m0 = 8'h00;
                m1 = 8'h00;
                check("dvalid_in_reset", {30'd0, dvalid}, 32'd0);
            end else if (dvalid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_dvalid", {30'd0, dvalid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("dvalid", {30'd0, dvalid}, {30'd0, e.dv});
                    if (e.core) m1 = e.data;
                    else        m0 = e.data;
                end
            end
            check("Dq", {16'd0, Dq}, {16'd0, m0, m1});
            rst_seen = rst_n;
        end
    end

    initial begin
        vec_t       tv [10];
        logic [1:0] exp_acq;
        logic [7:0] exp_addr;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[5] = 8'hA7;

        // req, a0, a1, drop-in-ADDR, expected winner (0/1)
        tv[0] = '{2'b11, 8'h10, 8'h20, 1'b0, 1'b0};
        tv[1] = '{2'b11, 8'h10, 8'h20, 1'b0, RR};
        tv[2] = '{2'b11, 8'h10, 8'h20, 1'b0, 1'b0};
        tv[3] = '{2'b11, 8'h10, 8'h20, 1'b0, RR};
        tv[4] = '{2'b01, 8'h00, 8'h05, 1'b0, 1'b1};
        tv[5] = '{2'b01, 8'h00, 8'h33, 1'b0, 1'b1};
        tv[6] = '{2'b10, 8'h44, 8'h00, 1'b1, 1'b0};
        tv[7] = '{2'b10, 8'h55, 8'h00, 1'b0, 1'b0};
        tv[8] = '{2'b11, 8'h66, 8'h77, 1'b0, RR};
        tv[9] = '{2'b11, 8'h88, 8'h99, 1'b1, 1'b0};

        rst_n = 1'b0;
        req   = 2'b11;
        a0    = 8'h10;
        a1    = 8'h20;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acq",     {30'd0, acq},    32'd0);
        check("rst_dvalid",  {30'd0, dvalid}, 32'd0);
        check("rst_Dq",      {16'd0, Dq},     32'd0);
        check("rst_busy",    {31'd0, busy},   32'd0);
        check("rst_ramaddr", {24'd0, RAMAddress}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req      = tv[i].req;
            a0       = tv[i].a0;
            a1       = tv[i].a1;
            exp_acq  = tv[i].core ? 2'b01 : 2'b10;
            exp_addr = tv[i].core ? tv[i].a1 : tv[i].a0;
            @(negedge clk);
            check("grant_acq",  {30'd0, acq},        {30'd0, exp_acq});
            check("grant_addr", {24'd0, RAMAddress}, {24'd0, exp_addr});
            check("grant_busy", {31'd0, busy},       32'd1);
            sb_q.push_back('{dv: exp_acq, core: tv[i].core, data: mem[exp_addr]});
            a0 = 8'hFF;
            a1 = 8'hFF;
            if (tv[i].drop) req = 2'b00;
            @(negedge clk);
            check("acq_hold",  {30'd0, acq},        {30'd0, exp_acq});
            check("addr_hold", {24'd0, RAMAddress}, {24'd0, exp_addr});
            @(negedge clk);
            check("acq_release", {30'd0, acq},  32'd0);
            check("idle_busy",   {31'd0, busy}, 32'd0);
        end

        // Reset in the DATA cycle: transfer dropped, pointer back to 0.
        req = 2'b10;
        a0  = 8'h3C;
        @(negedge clk);
        check("abort_grant", {30'd0, acq}, 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_acq",     {30'd0, acq},        32'd0);
        check("abort_busy",    {31'd0, busy},       32'd0);
        check("abort_dvalid",  {30'd0, dvalid},     32'd0);
        check("abort_ramaddr", {24'd0, RAMAddress}, 32'd0);
        rst_n = 1'b1;
        req   = 2'b11;
        a0    = 8'h12;
        a1    = 8'h34;
        @(negedge clk);
        check("post_reset_grant", {30'd0, acq},        32'h2);
        check("post_reset_addr",  {24'd0, RAMAddress}, 32'h12);
        sb_q.push_back('{dv: 2'b10, core: 1'b0, data: mem[8'h12]});
        @(negedge clk);
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iram_arbiter.md
# iram_arbiter

Round-robin fetch arbiter that shares the single-port synchronous instruction RAM between the processor cores of the multicore top level. Each core raises a level request with its fetch address. The arbiter grants one core at a time, drives the RAM address, and captures the RAM output into that core's private data register with a one-cycle valid pulse. It is the instruction-side companion of the data-memory controller and sits between the cores and the IRAM instance.

## Interface
Parameters:
- NCORES, 2, number of requesting cores (2..8)
- AW, 8, instruction address width
- DW, 8, instruction word width

Ports (the bus packing puts core 0 in the most significant slice, i.e. {core0, core1, ...}):
- CLK  input  1  system clock (divided clock); all logic on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on CLK rising edge
- req  input  NCORES  per-core fetch request, level, packed {core0,...}
- Address  input  NCORES*AW  per-core fetch addresses, packed
- RAMq  input  DW  IRAM read data
- RAMAddress  output  AW  IRAM address, registered
- acq  output  NCORES  one-hot grant; high from grant until capture
- Dq  output  NCORES*DW  per-core fetched instruction, registered, packed
- dvalid  output  NCORES  per-core one-cycle pulse: Dq slice updated
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE: if req is nonzero, choose a winner w, load RAMAddress<=Address[w], set acq to one-hot(w), store w and go to ADDR. Otherwise stay in IDLE.
  - ADDR: IRAM registers RAMAddress at the end of this cycle. Go to DATA unconditionally.
  - DATA: RAMq holds the word. At the edge, set Dq[w]<=RAMq, dvalid[w]<=1, acq<=0, ptr<=(w+1) mod NCORES, and go to IDLE.
- Round-robin winner: the first set bit of req, searching upward from index ptr with wrap to 0.
- Address[w] is sampled only at the grant edge. Later changes to Address or req do not affect the transfer in flight.
- If req[w] drops during ADDR or DATA, the transfer still completes and dvalid[w] still pulses.
- Cores hold req until they see dvalid, then deassert or present the next address.
- Dq slices of non-granted cores hold their values. The granted core's slice holds its value until its next capture.
- Requests arriving while busy are not queued. They are evaluated in the next IDLE cycle.
- No arithmetic beyond the mod-NCORES pointer increment. ptr is $clog2(NCORES) bits wide. Indices ≥ NCORES never win.

## Timing
- Reset values (rst_n=0 at an edge): state=IDLE, ptr=0, RAMAddress=0, acq=0, Dq=0, dvalid=0, busy=0.
- Reset mid-transfer aborts it: no dvalid pulse, and the transfer is lost.
- Latency: grant edge at T0, capture edge at T0+2, so dvalid is high during cycle T0+2..T0+3. The earliest next grant is at T0+3.
- Throughput: one fetch per 3 cycles, aggregated over all cores.
- dvalid is exactly one cycle wide and never asserts for more than one core at a time.
- acq is high for exactly 2 cycles per grant.
- Simultaneous requests at IDLE go to the winner chosen from ptr.
- A core that holds req continuously gets one fetch in every NCORES grants when all cores request.

## Configuration
- Macro: IARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index set bit of req and ptr is unused (held at 0). Core 0 can starve the others.
- Undefined (default): the round-robin policy above.
- The FSM, latency and all other behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with req=2'b11 -> all outputs 0 and busy=0. After release, the first grant goes to core 0.
- Single fetch: core1 req=1 with Address1=8'h05 and RAM[5]=8'hA7 -> RAMAddress=8'h05 at T0+1, acq=2'b01 for 2 cycles, Dq1=8'hA7 with dvalid=2'b01 for 1 cycle at T0+2.
- Contention: req=2'b11 held, Address0=8'h10, Address1=8'h20 -> grant order core0, core1, core0, ... with dvalid every 3 cycles.
- Early drop: core0 requests then drops req in the ADDR cycle -> dvalid[0] still pulses at T0+2 and Dq0 holds RAM[Address0].
- Reset mid-transfer: rst_n=0 in the DATA cycle -> no dvalid, state=IDLE, ptr=0.
- IARB_FIXED_PRIO_EN build with req=2'b11 held -> only core 0 is ever granted and dvalid[1] never asserts.
